voice_allocator: RTL and testbench

- Polyphonic voice scheduler between the PS2 keyboard decode and the three oscillator instances.
- Each decoded key press is assigned to one oscillator voice; each key release gates that voice off.
- When all voices are busy, the oldest held voice is stolen.
- Drives a per-voice note and gate in place of the single shared note feeding every oscillator today.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/voice_allocator.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: note encoding, index sizing helper and the
// voice allocator state encoding.
package synth_pkg;

  localparam int NOTE_W = 5;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t NOTE_NONE = '0;

  // Bits needed to index n voices (never less than one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    RETRIG
  } state_t;

endpackage

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns key presses to oscillator voices, gates
// voices off on release and steals the oldest held voice when all are busy.
// Voices are examined one per cycle through a fetch/compare pipeline so a
// single comparator serves every voice.
// Optional build macro: SYNTH_SUSTAIN_PEDAL_EN adds a sustain input and a
// per-voice pending-off bit that defers matched releases until pedal release.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = synth_pkg::NOTE_W,
  parameter int AGE_W      = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              key_valid,
  output logic                              key_ready,
  input  logic [NOTE_W-1:0]                 key_note,
  input  logic                              key_release,
`ifdef SYNTH_SUSTAIN_PEDAL_EN
  input  logic                              sustain,
`endif
  output logic [NUM_VOICES*NOTE_W-1:0]      voice_note,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic                              steal_pulse,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count
);

  localparam int IDX_W  = idx_width(NUM_VOICES);
  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int SCNT_W = $clog2(NUM_VOICES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t state;

  logic [NOTE_W-1:0] notes   [NUM_VOICES];
  logic [AGE_W-1:0]  ages    [NUM_VOICES];
  logic [NOTE_W-1:0] notes_n [NUM_VOICES];
  logic [AGE_W-1:0]  ages_n  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gates_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              steal_n;
  logic              do_retrig;
  logic [IDX_W-1:0]  tgt;
  logic [IDX_W-1:0]  tgt_q;

  logic [NOTE_W-1:0] ev_note;
  logic              ev_release;

  logic [SCNT_W-1:0] scan_cnt;
  logic              fetch_valid;
  logic [IDX_W-1:0]  fetch_idx;
  logic [NOTE_W-1:0] fetch_note;
  logic              fetch_gate;
  logic [AGE_W-1:0]  fetch_age;
  logic [NOTE_W-1:0] mux_note;
  logic              mux_gate;
  logic [AGE_W-1:0]  mux_age;

  logic              match_found;
  logic [IDX_W-1:0]  match_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [AGE_W-1:0]  free_age;
  logic              held_found;
  logic [IDX_W-1:0]  held_idx;
  logic [AGE_W-1:0]  held_age;

`ifdef SYNTH_SUSTAIN_PEDAL_EN
  logic                  ev_sustain;
  logic                  sustain_q;
  logic                  pedal_defer;
  logic                  pedal_fall;
  logic [NUM_VOICES-1:0] pending;
  logic [NUM_VOICES-1:0] pending_n;

  assign pedal_fall = sustain_q & ~sustain;
`endif

  // Flatten the per-voice note registers onto the packed output bus
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[g*NOTE_W +: NOTE_W] = notes[g];
  end

  // Select the voice addressed by the scan counter for the fetch stage
  always_comb begin
    mux_note = '0;
    mux_gate = 1'b0;
    mux_age  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (SCNT_W'(i) == scan_cnt) begin
        mux_note = notes[i];
        mux_gate = voice_gate[i];
        mux_age  = ages[i];
      end
    end
  end

  // Compute the next voice state: event commit, retrigger re-gate and pedal release
  always_comb begin
    notes_n   = notes;
    ages_n    = ages;
    gates_n   = voice_gate;
    steal_n   = 1'b0;
    do_retrig = 1'b0;
    tgt       = '0;
`ifdef SYNTH_SUSTAIN_PEDAL_EN
    pending_n = pending;
`endif
    if (state == COMMIT) begin
      if (ev_release) begin
        if (match_found) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == match_idx) begin
`ifdef SYNTH_SUSTAIN_PEDAL_EN
              if (ev_sustain) pending_n[i] = 1'b1;
              else            gates_n[i]   = 1'b0;
`else
              gates_n[i] = 1'b0;
`endif
            end
          end
        end
      end else begin
        if (match_found) begin
          tgt       = match_idx;
          do_retrig = 1'b1;
        end else if (free_found) begin
          tgt = free_idx;
        end else begin
          tgt     = held_idx;
          steal_n = 1'b1;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == tgt) begin
            ages_n[i]  = '0;
            gates_n[i] = ~match_found;
            if (!match_found) notes_n[i] = ev_note;
`ifdef SYNTH_SUSTAIN_PEDAL_EN
            pending_n[i] = 1'b0;
`endif
          end else if (ages[i] != AGE_MAX) begin
            ages_n[i] = ages[i] + 1'b1;
          end
        end
      end
    end else if (state == RETRIG) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == tgt_q) gates_n[i] = 1'b1;
      end
    end
`ifdef SYNTH_SUSTAIN_PEDAL_EN
    if ((state != COMMIT) && (pedal_fall || pedal_defer)) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (pending_n[i]) gates_n[i] = 1'b0;
      end
      pending_n = '0;
    end
`endif
    cnt_n = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cnt_n = cnt_n + CNT_W'(gates_n[i]);
    end
  end

  // Allocator FSM with registered voice state, handshake and scan records
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      key_ready    <= 1'b1;
      voice_gate   <= '0;
      steal_pulse  <= 1'b0;
      active_count <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes[i] <= '0;
        ages[i]  <= '0;
      end
      tgt_q       <= '0;
      ev_note     <= '0;
      ev_release  <= 1'b0;
      scan_cnt    <= '0;
      fetch_valid <= 1'b0;
      fetch_idx   <= '0;
      fetch_note  <= '0;
      fetch_gate  <= 1'b0;
      fetch_age   <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      free_age    <= '0;
      held_found  <= 1'b0;
      held_idx    <= '0;
      held_age    <= '0;
`ifdef SYNTH_SUSTAIN_PEDAL_EN
      ev_sustain  <= 1'b0;
      sustain_q   <= 1'b0;
      pedal_defer <= 1'b0;
      pending     <= '0;
`endif
    end else begin
      notes        <= notes_n;
      ages         <= ages_n;
      voice_gate   <= gates_n;
      steal_pulse  <= steal_n;
      active_count <= cnt_n;
`ifdef SYNTH_SUSTAIN_PEDAL_EN
      pending     <= pending_n;
      sustain_q   <= sustain;
      pedal_defer <= (state == COMMIT) ? (pedal_defer | pedal_fall) : 1'b0;
`endif
      case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
            ev_note    <= key_note;
            ev_release <= key_release;
`ifdef SYNTH_SUSTAIN_PEDAL_EN
            ev_sustain <= sustain;
`endif
            if (key_note != NOTE_W'(NOTE_NONE)) begin
              state       <= SCAN;
              key_ready   <= 1'b0;
              scan_cnt    <= '0;
              fetch_valid <= 1'b0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              held_found  <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (fetch_valid) begin
            if (fetch_gate) begin
              if (!match_found && (fetch_note == ev_note)) begin
                match_found <= 1'b1;
                match_idx   <= fetch_idx;
              end
              if (!held_found || (fetch_age > held_age)) begin
                held_found <= 1'b1;
                held_idx   <= fetch_idx;
                held_age   <= fetch_age;
              end
            end else if (!free_found || (fetch_age > free_age)) begin
              free_found <= 1'b1;
              free_idx   <= fetch_idx;
              free_age   <= fetch_age;
            end
          end
          if (scan_cnt == SCNT_W'(NUM_VOICES)) begin
            fetch_valid <= 1'b0;
            state       <= COMMIT;
          end else begin
            fetch_valid <= 1'b1;
            fetch_idx   <= IDX_W'(scan_cnt);
            fetch_note  <= mux_note;
            fetch_gate  <= mux_gate;
            fetch_age   <= mux_age;
            scan_cnt    <= scan_cnt + 1'b1;
          end
        end
        COMMIT: begin
          tgt_q <= tgt;
          if (do_retrig) begin
            state <= RETRIG;
          end else begin
            state     <= IDLE;
            key_ready <= 1'b1;
          end
        end
        RETRIG: begin
          state     <= IDLE;
          key_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a table of key events with
// hand-computed voice state, plus hand sequences for reset mid-scan,
// retrigger and (when SYNTH_SUSTAIN_PEDAL_EN is defined) the sustain pedal.
module tb_voice_allocator;

  logic        clk;
  logic        reset_n;
  logic        key_valid;
  logic        key_ready;
  logic [4:0]  key_note;
  logic        key_release;
  logic        sustain;
  logic [14:0] voice_note;
  logic [2:0]  voice_gate;
  logic        steal_pulse;
  logic [1:0]  active_count;

  int checks;
  int errors;

  voice_allocator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_note     (key_note),
    .key_release  (key_release),
`ifdef SYNTH_SUSTAIN_PEDAL_EN
    .sustain      (sustain),
`endif
    .voice_note   (voice_note),
    .voice_gate   (voice_gate),
    .steal_pulse  (steal_pulse),
    .active_count (active_count)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        rel;
    logic [4:0]  note;
    logic [14:0] exp_notes;
    logic [2:0]  exp_gates;
    logic [1:0]  exp_count;
    int          exp_lat;
    int          exp_steals;
    int          exp_glitch;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string tag, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", tag, idx, act, exp);
    end
  endtask

  // Offer one event, then watch until key_ready returns (bounded)
  task automatic applyStimulus(input logic rel, input logic [4:0] note,
                               input logic [2:0] exp_gates,
                               output int lat, output int steals, output int glitch);
    logic [2:0] pre;
    pre = voice_gate;
    @(negedge clk);
    key_valid   = 1'b1;
    key_note    = note;
    key_release = rel;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    lat    = -1;
    steals = 0;
    glitch = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (steal_pulse) steals++;
      if ((voice_gate != pre) && (voice_gate != exp_gates)) glitch++;
      if (key_ready) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int steals;
    int glitch;
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    key_valid   = 1'b0;
    key_note    = '0;
    key_release = 1'b0;
    sustain     = 1'b0;

    vecs[0]  = '{1'b0, 5'd5,  {5'd0,  5'd0,  5'd5},  3'b001, 2'd1, 5, 0, 0};
    vecs[1]  = '{1'b0, 5'd7,  {5'd0,  5'd7,  5'd5},  3'b011, 2'd2, 5, 0, 0};
    vecs[2]  = '{1'b0, 5'd9,  {5'd9,  5'd7,  5'd5},  3'b111, 2'd3, 5, 0, 0};
    vecs[3]  = '{1'b0, 5'd11, {5'd9,  5'd7,  5'd11}, 3'b111, 2'd3, 5, 1, 0};
    vecs[4]  = '{1'b1, 5'd7,  {5'd9,  5'd7,  5'd11}, 3'b101, 2'd2, 5, 0, 0};
    vecs[5]  = '{1'b1, 5'd12, {5'd9,  5'd7,  5'd11}, 3'b101, 2'd2, 5, 0, 0};
    vecs[6]  = '{1'b0, 5'd0,  {5'd9,  5'd7,  5'd11}, 3'b101, 2'd2, 1, 0, 0};
    vecs[7]  = '{1'b0, 5'd9,  {5'd9,  5'd7,  5'd11}, 3'b101, 2'd2, 6, 0, 1};
    vecs[8]  = '{1'b0, 5'd13, {5'd9,  5'd13, 5'd11}, 3'b111, 2'd3, 5, 0, 0};
    vecs[9]  = '{1'b1, 5'd11, {5'd9,  5'd13, 5'd11}, 3'b110, 2'd2, 5, 0, 0};
    vecs[10] = '{1'b1, 5'd9,  {5'd9,  5'd13, 5'd11}, 3'b010, 2'd1, 5, 0, 0};
    vecs[11] = '{1'b0, 5'd7,  {5'd9,  5'd13, 5'd7},  3'b011, 2'd2, 5, 0, 0};
    vecs[12] = '{1'b0, 5'd20, {5'd20, 5'd13, 5'd7},  3'b111, 2'd3, 5, 0, 0};
    vecs[13] = '{1'b0, 5'd21, {5'd20, 5'd21, 5'd7},  3'b111, 2'd3, 5, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset notes", 0, 32'(voice_note), 32'h0);
    checkOutput("reset gates", 0, 32'(voice_gate), 32'h0);
    checkOutput("reset count", 0, 32'(active_count), 32'h0);
    checkOutput("reset ready", 0, 32'(key_ready), 32'h1);
    checkOutput("reset steal", 0, 32'(steal_pulse), 32'h0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rel, vecs[i].note, vecs[i].exp_gates, lat, steals, glitch);
      checkOutput("latency", i, 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput("notes", i, 32'(voice_note), 32'(vecs[i].exp_notes));
      checkOutput("gates", i, 32'(voice_gate), 32'(vecs[i].exp_gates));
      checkOutput("count", i, 32'(active_count), 32'(vecs[i].exp_count));
      checkOutput("steals", i, 32'(steals), 32'(vecs[i].exp_steals));
      checkOutput("gate glitch", i, 32'(glitch), 32'(vecs[i].exp_glitch));
    end

    // Reset asserted in the middle of a scan abandons the event
    @(negedge clk);
    key_valid   = 1'b1;
    key_note    = 5'd3;
    key_release = 1'b0;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midscan reset notes", 100, 32'(voice_note), 32'h0);
    checkOutput("midscan reset gates", 100, 32'(voice_gate), 32'h0);
    checkOutput("midscan reset ready", 100, 32'(key_ready), 32'h1);
    checkOutput("midscan reset count", 100, 32'(active_count), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abandoned event gates", 101, 32'(voice_gate), 32'h0);

    // Press 5 twice: second press retriggers voice0 only
    applyStimulus(1'b0, 5'd5, 3'b001, lat, steals, glitch);
    checkOutput("fresh press latency", 102, 32'(lat), 32'd5);
    checkOutput("fresh press notes", 102, 32'(voice_note), 32'(15'd5));
    checkOutput("fresh press gates", 102, 32'(voice_gate), 32'h1);
    applyStimulus(1'b0, 5'd5, 3'b001, lat, steals, glitch);
    checkOutput("retrig latency", 103, 32'(lat), 32'd6);
    checkOutput("retrig low cycles", 103, 32'(glitch), 32'd1);
    checkOutput("retrig notes", 103, 32'(voice_note), 32'(15'd5));
    checkOutput("retrig gates", 103, 32'(voice_gate), 32'h1);
    checkOutput("retrig count", 103, 32'(active_count), 32'h1);

`ifdef SYNTH_SUSTAIN_PEDAL_EN
    // Sustain holds a released voice until the pedal is lifted
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sustain = 1'b1;
    applyStimulus(1'b0, 5'd5, 3'b001, lat, steals, glitch);
    checkOutput("sustain press gates", 200, 32'(voice_gate), 32'h1);
    applyStimulus(1'b1, 5'd5, 3'b001, lat, steals, glitch);
    checkOutput("sustain release latency", 201, 32'(lat), 32'd5);
    checkOutput("sustained gates", 201, 32'(voice_gate), 32'h1);
    @(negedge clk);
    sustain = 1'b0;
    #1;
    checkOutput("pedal before edge gates", 202, 32'(voice_gate), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("pedal release gates", 203, 32'(voice_gate), 32'h0);
    checkOutput("pedal release count", 203, 32'(active_count), 32'h0);
    checkOutput("pedal release note kept", 203, 32'(voice_note), 32'(15'd5));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
